seq_shift_add_mult: RTL and testbench

- Parametrised sequential shift-add multiplier: WIDTH-bit multiplicand A times WIDTH-bit multiplier B, producing a 2*WIDTH-bit product.
- Adds a run-time signed/unsigned mode, a registered and held result, a ready/busy/done handshake, and an asynchronous reset.
- Sits in the benchmark arithmetic set as the scalable successor of the fixed 4x4 controller/datapath multiplier.
- Intended for sweeping width in locking and attack experiments.

---
 rtl/seq_shift_add_mult.sv | 169 ++++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_shift_add_mult
// Sequential shift-add multiplier. It takes one iteration per clock and
// produces a 2*WIDTH-bit product from two WIDTH-bit operands. A run-time mode
// selects signed (two's-complement) or unsigned operands. The product is
// registered and held. A READY/BUSY/DONE handshake reports progress.
//
// Ports
//   CK     in   rising-edge clock
//   RN     in   asynchronous active-low reset
//   START  in   load operands and begin (restarts an in-flight operation)
//   SIGNED in   two's-complement mode, sampled with START
//   A      in   multiplicand, sampled with START
//   B      in   multiplier, sampled with START
//   P      out  product register; updated only on completion
//   READY  out  idle or finishing; a START is accepted
//   BUSY   out  iterating
//   DONE   out  one-cycle pulse while P first shows a new product
//   CNT    out  iteration counter, exposed for test
// -----------------------------------------------------------------------------
module seq_shift_add_mult #(
  parameter int WIDTH     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic                         CK,
  input  logic                         RN,
  input  logic                         START,
  input  logic                         SIGNED,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  output logic [2*WIDTH-1:0]           P,
  output logic                         READY,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [$clog2(WIDTH+1)-1:0]   CNT
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH:0]      acc_q, acc_d;     // upper half plus a guard bit
  logic [WIDTH-1:0]    mr_q, mr_d;       // multiplier, shifts out as product lower half
  logic [WIDTH-1:0]    ar_q, ar_d;       // multiplicand
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mode_q, mode_d;   // 1 = signed operation
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic                done_q, done_d;

  logic [WIDTH:0]      ar_ext_s;
  logic [WIDTH:0]      sum_s;
  logic                signed_mode_s;

  // SIGNED only takes effect when the signed feature is built in
  assign signed_mode_s = SIGNED & (SIGNED_EN != 0);

  // Extend the multiplicand to the accumulator width for the current mode
  always_comb begin
    if (mode_q) begin
      ar_ext_s = {ar_q[WIDTH-1], ar_q};
    end else begin
      ar_ext_s = {1'b0, ar_q};
    end
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mr_d    = mr_q;
    ar_d    = ar_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    p_d     = p_q;
    done_d  = 1'b0;
    sum_s   = acc_q;

    // The product update and the DONE pulse happen on leaving FIN even if
    // a new START is accepted on that same edge.
    if (state_q == ST_FIN) begin
      p_d    = {acc_q[WIDTH-1:0], mr_q};
      done_d = 1'b1;
    end else begin
      p_d    = p_q;
      done_d = 1'b0;
    end

    if (START) begin
      // Accepted in every state: a START during RUN aborts the current operation.
      ar_d    = A;
      mr_d    = B;
      acc_d   = '0;
      cnt_d   = '0;
      mode_d  = signed_mode_s;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (mr_q[0]) begin
            // The MSB of a signed multiplier has negative weight, so the
            // final partial product is subtracted.
            if (mode_q && (cnt_q == CNT_LAST)) begin
              sum_s = acc_q - ar_ext_s;
            end else begin
              sum_s = acc_q + ar_ext_s;
            end
          end else begin
            sum_s = acc_q;
          end
          acc_d = {(mode_q ? sum_s[WIDTH] : 1'b0), sum_s[WIDTH:1]};
          mr_d  = {sum_s[0], mr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mr_q    <= '0;
      ar_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      ar_q    <= ar_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign P     = p_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q == ST_RUN);
  assign READY = (state_q != ST_RUN);
  assign CNT   = cnt_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
`timescale 1ns/1ps
// Bench for seq_shift_add_mult: directed WIDTH=4 scenarios (signed and
// unsigned-only builds) plus a randomized WIDTH=8 run against an arithmetic
// reference model.
module tb_seq_shift_add_mult;

  logic ck = 1'b0;
  logic rn;
  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // WIDTH=4, signed capable
  logic       s4_start, s4_signed;
  logic [3:0] s4_a, s4_b;
  logic [7:0] p4;
  logic       ready4, busy4, done4;
  logic [2:0] cnt4;
  // WIDTH=4, unsigned-only build
  logic       u_start, u_signed;
  logic [3:0] u_a, u_b;
  logic [7:0] p4u;
  logic       ready4u, busy4u, done4u;
  logic [2:0] cnt4u;
  // WIDTH=8, signed capable
  logic       s8_start, s8_signed;
  logic [7:0] s8_a, s8_b;
  logic [15:0] p8;
  logic       ready8, busy8, done8;
  logic [3:0] cnt8;

  seq_shift_add_mult #(.WIDTH(4), .SIGNED_EN(1)) dut4 (
    .CK(ck), .RN(rn), .START(s4_start), .SIGNED(s4_signed), .A(s4_a), .B(s4_b),
    .P(p4), .READY(ready4), .BUSY(busy4), .DONE(done4), .CNT(cnt4));

  seq_shift_add_mult #(.WIDTH(4), .SIGNED_EN(0)) dut4u (
    .CK(ck), .RN(rn), .START(u_start), .SIGNED(u_signed), .A(u_a), .B(u_b),
    .P(p4u), .READY(ready4u), .BUSY(busy4u), .DONE(done4u), .CNT(cnt4u));

  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .CK(ck), .RN(rn), .START(s8_start), .SIGNED(s8_signed), .A(s8_a), .B(s8_b),
    .P(p8), .READY(ready8), .BUSY(busy8), .DONE(done8), .CNT(cnt8));

  int done8_cnt = 0;
  always @(negedge ck) begin
    if (done8 === 1'b1) done8_cnt++;
  end

  // Reference: interpret operands per mode, multiply, keep 2*w bits.
  function automatic longint ref_mult(input int w, input longint a, input longint b, input bit s);
    longint x, y, m;
    x = a;
    y = b;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return (x * y) & m;
  endfunction

  function automatic logic [7:0] pick8();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // One complete WIDTH=4 operation; reports what was seen, callers compare.
  task automatic run4(input bit on_u, input logic [3:0] a, input logic [3:0] b, input logic s,
                      output logic [7:0] p_obs, output logic done_obs, output int early);
    early = 0;
    @(negedge ck);
    if (on_u) begin u_start = 1'b1; u_a = a; u_b = b; u_signed = s; end
    else begin s4_start = 1'b1; s4_a = a; s4_b = b; s4_signed = s; end
    @(negedge ck);
    u_start = 1'b0;
    s4_start = 1'b0;
    repeat (4) begin
      @(negedge ck);
      if ((on_u ? done4u : done4) === 1'b1) early++;
    end
    @(negedge ck);
    p_obs    = on_u ? p4u : p4;
    done_obs = on_u ? done4u : done4;
  endtask

  task automatic test_reset();
    rn = 1'b0;
    #1;
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_p4 got %h want 00", p4); end
    checks++; if ({ready4, busy4, done4} !== 3'b100) begin errors++; $display("FAIL reset_hs4 got %b want 100", {ready4, busy4, done4}); end
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL reset_cnt4 got %0d want 0", cnt4); end
    checks++; if ({p8, ready8, busy8, done8, cnt8} !== {16'h0000, 3'b100, 4'd0}) begin errors++; $display("FAIL reset_dut8 got p=%h r/b/d=%b%b%b cnt=%0d", p8, ready8, busy8, done8, cnt8); end
    repeat (2) @(negedge ck);
    rn = 1'b1;
    @(negedge ck);
    checks++; if ({p4, ready4, busy4, done4} !== {8'h00, 3'b100}) begin errors++; $display("FAIL post_reset_idle got p=%h r/b/d=%b%b%b", p4, ready4, busy4, done4); end
  endtask

  task automatic test_unsigned_basic();
    @(negedge ck);
    s4_start = 1'b1; s4_a = 4'd15; s4_b = 4'd15; s4_signed = 1'b0;
    @(negedge ck);
    s4_start = 1'b0;
    s4_a = 4'd3; s4_b = 4'd9; s4_signed = 1'b1;   // ignored while not sampling
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy4 !== 1'b1 || ready4 !== 1'b0 || cnt4 !== 3'(k) || done4 !== 1'b0) begin
        errors++; $display("FAIL run_cycle%0d got busy=%b ready=%b cnt=%0d done=%b want 1 0 %0d 0", k, busy4, ready4, cnt4, done4, k);
      end
      @(negedge ck);
    end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || ready4 !== 1'b1) begin errors++; $display("FAIL fin_cycle got busy=%b done=%b ready=%b want 0 0 1", busy4, done4, ready4); end
    @(negedge ck);
    checks++; if (done4 !== 1'b1 || p4 !== 8'hE1) begin errors++; $display("FAIL done_15x15 got done=%b p=%h want 1 e1", done4, p4); end
    repeat (3) begin
      @(negedge ck);
      checks++; if (done4 !== 1'b0 || p4 !== 8'hE1 || ready4 !== 1'b1) begin errors++; $display("FAIL hold_e1 got done=%b p=%h ready=%b want 0 e1 1", done4, p4, ready4); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] p; logic d; int e;
    run4(1'b0, 4'b1000, 4'b1000, 1'b1, p, d, e);
    checks++; if (p !== 8'h40 || d !== 1'b1 || e != 0) begin errors++; $display("FAIL signed_m8xm8 got p=%h done=%b early=%0d want 40 1 0", p, d, e); end
    run4(1'b0, 4'b1000, 4'd7, 1'b1, p, d, e);
    checks++; if (p !== 8'hC8 || d !== 1'b1 || e != 0) begin errors++; $display("FAIL signed_m8x7 got p=%h done=%b early=%0d want c8 1 0", p, d, e); end
    run4(1'b1, 4'b1000, 4'd7, 1'b1, p, d, e);
    checks++; if (p !== 8'h38 || d !== 1'b1 || e != 0) begin errors++; $display("FAIL unsigned_only_8x7 got p=%h done=%b early=%0d want 38 1 0", p, d, e); end
    run4(1'b1, 4'hF, 4'hF, 1'b1, p, d, e);
    checks++; if (p !== 8'hE1) begin errors++; $display("FAIL unsigned_only_15x15 got p=%h want e1", p); end
  endtask

  task automatic test_abort();
    int dcount, dpos;
    @(negedge ck);
    s4_start = 1'b1; s4_a = 4'd3; s4_b = 4'd5; s4_signed = 1'b0;
    @(negedge ck);
    s4_start = 1'b0;
    repeat (2) begin
      @(negedge ck);
      checks++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL abort_first_run got busy=%b done=%b want 1 0", busy4, done4); end
    end
    s4_start = 1'b1; s4_a = 4'd2; s4_b = 4'd6;
    @(negedge ck);
    s4_start = 1'b0;
    checks++; if (cnt4 !== 3'd0 || busy4 !== 1'b1 || p4 !== 8'hC8) begin errors++; $display("FAIL abort_reload got cnt=%0d busy=%b p=%h want 0 1 c8", cnt4, busy4, p4); end
    dcount = 0; dpos = -1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge ck);
      if (done4 === 1'b1) begin dcount++; dpos = j; end
      if (j < 5) begin
        checks++; if (p4 !== 8'hC8) begin errors++; $display("FAIL abort_p_held got %h want c8", p4); end
      end
    end
    checks++; if (dcount != 1 || dpos != 5) begin errors++; $display("FAIL abort_done got count=%0d pos=%0d want 1 5", dcount, dpos); end
    checks++; if (p4 !== 8'h0C) begin errors++; $display("FAIL abort_p got %h want 0c", p4); end
  endtask

  task automatic test_async_reset();
    logic [7:0] p; logic d; int e;
    run4(1'b0, 4'd15, 4'd15, 1'b0, p, d, e);
    checks++; if (p !== 8'hE1) begin errors++; $display("FAIL pre_reset_p got %h want e1", p); end
    @(negedge ck);
    s4_start = 1'b1; s4_a = 4'd3; s4_b = 4'd3;
    @(negedge ck);
    s4_start = 1'b0;
    repeat (2) @(negedge ck);
    #2 rn = 1'b0;
    #1;
    checks++; if ({p4, ready4, busy4, done4, cnt4} !== {8'h00, 3'b100, 3'd0}) begin errors++; $display("FAIL async_reset got p=%h r/b/d=%b%b%b cnt=%0d want 00 100 0", p4, ready4, busy4, done4, cnt4); end
    @(negedge ck);
    rn = 1'b1;
    run4(1'b0, 4'd1, 4'd1, 1'b0, p, d, e);
    checks++; if (p !== 8'h01 || d !== 1'b1 || e != 0) begin errors++; $display("FAIL after_reset_1x1 got p=%h done=%b early=%0d want 01 1 0", p, d, e); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ca, cb;
    logic cs;
    longint expv;
    int expected_dones, base, k;
    bit launched;
    expected_dones = 0;
    launched = 1'b0;
    base = done8_cnt;
    for (int i = 0; i < 1000; i++) begin
      if (!launched) begin
        ca = pick8(); cb = pick8(); cs = 1'($urandom_range(0, 1));
        s8_a = ca; s8_b = cb; s8_signed = cs; s8_start = 1'b1;
        @(negedge ck);
      end
      s8_start = 1'b0;
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_signed = 1'($urandom_range(0, 1));
      expv = ref_mult(8, longint'(ca), longint'(cb), cs);
      launched = 1'b0;
      if (i < 999 && $urandom_range(0, 9) == 0) begin
        k = $urandom_range(1, 7);
        repeat (k) begin
          @(negedge ck);
          checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rand_abort_done op%0d got done=%b want 0", i, done8); end
        end
      end else begin
        for (int j = 1; j <= 8; j++) begin
          @(negedge ck);
          checks++;
          if (done8 !== 1'b0 || busy8 !== (j < 8)) begin
            errors++; $display("FAIL rand_run op%0d cyc%0d got done=%b busy=%b want 0 %b", i, j, done8, busy8, (j < 8));
          end
        end
        if (i < 999 && $urandom_range(0, 1) == 1) begin
          ca = pick8(); cb = pick8(); cs = 1'($urandom_range(0, 1));
          s8_a = ca; s8_b = cb; s8_signed = cs; s8_start = 1'b1;
          launched = 1'b1;
        end
        @(negedge ck);
        expected_dones++;
        checks++;
        if (done8 !== 1'b1 || p8 !== expv[15:0]) begin
          errors++; $display("FAIL rand_product op%0d got done=%b p=%h want 1 %h", i, done8, p8, expv[15:0]);
        end
        if (!launched) begin
          s8_start = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(negedge ck);
            checks++; if (done8 !== 1'b0 || p8 !== expv[15:0]) begin errors++; $display("FAIL rand_hold op%0d got done=%b p=%h want 0 %h", i, done8, p8, expv[15:0]); end
          end
        end
      end
    end
    s8_start = 1'b0;
    repeat (12) @(negedge ck);
    checks++; if (done8_cnt - base != expected_dones) begin errors++; $display("FAIL rand_done_count got %0d want %0d", done8_cnt - base, expected_dones); end
  endtask

  initial begin
    s4_start = 1'b0; s4_signed = 1'b0; s4_a = 4'd0; s4_b = 4'd0;
    u_start = 1'b0; u_signed = 1'b0; u_a = 4'd0; u_b = 4'd0;
    s8_start = 1'b0; s8_signed = 1'b0; s8_a = 8'd0; s8_b = 8'd0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
